// File: rtl/demux_channel_dispatcher.sv
// Byte-stream front end for the 1-to-4 demux path: routes each accepted byte into one of
// four single-entry channel holding registers, chosen by an explicit select or a round-robin pointer.
module demux_channel_dispatcher #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ch_ready,
    output logic [3:0]        ch_valid,
    output logic [DATA_W-1:0] ch0_data,
    output logic [DATA_W-1:0] ch1_data,
    output logic [DATA_W-1:0] ch2_data,
    output logic [DATA_W-1:0] ch3_data,
    output logic              s0,
    output logic              s1,
    output logic [1:0]        rr_ptr,
    output logic [CNT_W-1:0]  byte_count
);

    logic [1:0]        tgt;
    logic              accept;
    logic [3:0]        load;
    logic [3:0]        drain;
    logic [DATA_W-1:0] hold [4];

    // The routing decision is shared with downstream lanes, so s1/s0 always mirror the live target.
    always_comb begin
        tgt = mode ? rr_ptr : in_sel;
    end

    assign s0 = tgt[0];
    assign s1 = tgt[1];

    // A full channel that drains on this edge can take the new byte on the same edge.
    assign in_ready = !ch_valid[tgt] || ch_ready[tgt];
    assign accept   = in_valid && in_ready;
    assign drain    = ch_valid & ch_ready;

    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ch_valid   <= 4'b0000;
            rr_ptr     <= 2'd0;
            byte_count <= '0;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= '0;
            end
        end else begin
            // A refill wins over a drain so the channel stays full with the new byte.
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    hold[i]     <= in_data;
                    ch_valid[i] <= 1'b1;
                end else if (drain[i]) begin
                    ch_valid[i] <= 1'b0;
                end
            end
            if (accept) begin
                byte_count <= byte_count + CNT_W'(1);
                if (mode) begin
                    rr_ptr <= rr_ptr + 2'd1;
                end
            end
        end
    end

    assign ch0_data = hold[0];
    assign ch1_data = hold[1];
    assign ch2_data = hold[2];
    assign ch3_data = hold[3];

endmodule
